// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the E-stage mult/div issue controller and the mult/div unit.
// Holds the op encodings and the unit latencies so both sides use one source of truth.
package md_issue_ctrl_pkg;

  localparam int unsigned MD_OP_W      = 3;
  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'b000,
    MD_MULTU = 3'b001,
    MD_MULT  = 3'b010,
    MD_DIVU  = 3'b011,
    MD_DIV   = 3'b100
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_COMMIT = 2'd2
  } md_state_e;

  function automatic logic md_is_legal(input logic [MD_OP_W-1:0] op);
    return (op != 3'(MD_NONE)) && (op <= 3'(MD_DIV));
  endfunction

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == 3'(MD_DIVU)) || (op == 3'(MD_DIV));
  endfunction

endpackage

// File: rtl/md_sat_counter.sv
// Saturating event counter: counts enabled cycles, sticks at all-ones.
module md_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the mult/div unit: start code, busy mirror,
// D-stage HI/LO stall, stall-cycle counter and sticky protocol-error flag.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       e_md_op,
  input  logic             e_flush,
  input  logic             d_md_use,
  output logic [2:0]       md_start,
  output logic [CNT_W-1:0] md_busy,
  output logic             stall_d,
  output logic [31:0]      stall_cnt,
  output logic             err
);

  logic [CNT_W-1:0] r_busy;
  logic [CNT_W-1:0] w_busy_nxt;
  md_state_e        w_state;
  logic             w_legal;
  logic             w_issue;
  logic             w_stall;
  logic             w_err_set;
  logic             r_err;

  // State is a pure decode of the busy mirror.
  always_comb begin
    w_state = ST_IDLE;
    if (r_busy == CNT_W'(1)) begin
      w_state = ST_COMMIT;
    end else if (r_busy != '0) begin
      w_state = ST_BUSY;
    end
  end

  // State register: the busy mirror itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Next-state: load latency on issue, count down, clear on the commit edge.
  always_comb begin
    w_busy_nxt = r_busy;
    case (w_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_busy_nxt = md_is_div(e_md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end
      end
      ST_BUSY:   w_busy_nxt = r_busy - CNT_W'(1);
      ST_COMMIT: w_busy_nxt = '0;
      default:   w_busy_nxt = '0;
    endcase
  end

  // Outputs: start/stall are gated by reset so they read 0 while it is held.
  always_comb begin
    w_legal   = md_is_legal(e_md_op);
    w_issue   = w_legal && !e_flush && (w_state == ST_IDLE);
    md_start  = (w_issue && reset) ? e_md_op : 3'(MD_NONE);
    w_stall   = reset && d_md_use && ((w_state != ST_IDLE) || w_issue);
    w_err_set = !e_flush && ((w_legal && (w_state != ST_IDLE)) || (e_md_op > 3'(MD_DIV)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  md_sat_counter #(
    .W(32)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_stall),
    .o_cnt (stall_cnt)
  );

  assign md_busy = r_busy;
  assign stall_d = w_stall;
  assign err     = r_err;

endmodule
